buffer_read_sched: RTL

Read sequencer and port controller for the byte-addressable on-chip buffer in the router. It streams a programmed strided sequence of buffer entries onto a valid/ready output toward the PE array. It hides the buffer's 1-cycle registered read latency with a small output FIFO. Host writes pass straight through to the buffer write port, and read-after-write hazards on the same address are resolved by the scheduler.

---
 rtl/buffer_read_sched_pkg.sv | 22 ++
 rtl/buffer_read_sched_fifo.sv | 67 ++++++
 rtl/buffer_read_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/buffer_read_sched_pkg.sv
// Shared types and constants for the buffer read scheduler and its output FIFO.
package buffer_read_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } sched_state_e;

    localparam int FIFO_DEPTH = 3;

    function automatic logic [1:0] fifo_next_ptr(input logic [1:0] ptr);
        return (ptr == 2'(FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
    endfunction

    // A read may only issue while its landing slot is still guaranteed free.
    function automatic logic credit_ok(input logic [1:0] occ, input logic in_flight);
        return ({1'b0, occ} + {2'b00, in_flight}) < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/buffer_read_sched_fifo.sv
// Three-entry synchronous FIFO with occupancy output; head is readable combinationally.
module sync_fifo_small
    import buffer_read_sched_pkg::*;
#(
    parameter int DataWidth = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 pop,
    output logic [DataWidth-1:0] head_data,
    output logic                 full,
    output logic                 empty,
    output logic [1:0]           occupancy
);

    logic [DataWidth-1:0] mem_q [FIFO_DEPTH];
    logic [DataWidth-1:0] mem_d [FIFO_DEPTH];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] occ_q, occ_d;
    logic       do_push, do_pop;

    assign full      = (occ_q == 2'(FIFO_DEPTH));
    assign empty     = (occ_q == 2'd0);
    assign occupancy = occ_q;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = fifo_next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = fifo_next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/buffer_read_sched.sv
// Streams a strided run of buffer entries onto a valid/ready port, hiding the
// buffer's registered read latency behind a small credit-managed FIFO.
module buffer_read_sched
    import buffer_read_sched_pkg::*;
#(
    parameter int Depth     = 64,
    parameter int DataWidth = 8,
    parameter int AddrWidth = $clog2(Depth),
    parameter int CntWidth  = AddrWidth + 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [AddrWidth-1:0] baseAddr,
    input  logic [CntWidth-1:0]  count,
    input  logic [AddrWidth-1:0] stride,
    output logic                 busy,
    output logic                 done,
    input  logic                 hostWrEn,
    input  logic [AddrWidth-1:0] hostWrAddr,
    input  logic [DataWidth-1:0] hostWrData,
    output logic                 bufWriteEn,
    output logic [AddrWidth-1:0] bufWriteAddr,
    output logic [DataWidth-1:0] bufDataIn,
    output logic                 bufReadEn,
    output logic [AddrWidth-1:0] bufReadAddr,
    input  logic [DataWidth-1:0] bufDataOut,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [DataWidth-1:0] outData
);

    sched_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] stride_q, stride_d;
    logic [CntWidth-1:0]  rem_q, rem_d;
    logic                 in_flight_q, in_flight_d;

    logic                 read_en, hazard, fifo_pop;
    logic [DataWidth-1:0] fifo_head;
    logic                 fifo_full, fifo_empty;
    logic [1:0]           fifo_occ;

    assign bufWriteEn   = hostWrEn;
    assign bufWriteAddr = hostWrAddr;
    assign bufDataIn    = hostWrData;

    assign bufReadEn   = read_en;
    assign bufReadAddr = addr_q;
    assign outValid    = !fifo_empty;
    assign outData     = fifo_empty ? '0 : fifo_head;
    assign fifo_pop    = outValid && outReady;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    // Reading an address in the same cycle it is written would return stale data.
    assign hazard = hostWrEn && (hostWrAddr == addr_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        rem_d       = rem_q;
        read_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = baseAddr;
                    stride_d = stride;
                    rem_d    = count;
                    state_d  = (count == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (credit_ok(fifo_occ, in_flight_q) && !fifo_full && !hazard) begin
                    read_en = 1'b1;
                    addr_d  = addr_q + stride_q;
                    rem_d   = rem_q - CntWidth'(1);
                    if (rem_q == CntWidth'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the final entry is handed off so done follows that beat directly.
                if (!in_flight_q && (fifo_empty || (fifo_occ == 2'd1 && fifo_pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        in_flight_d = read_en;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            rem_q       <= '0;
            in_flight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            rem_q       <= rem_d;
            in_flight_q <= in_flight_d;
        end
    end

    sync_fifo_small #(
        .DataWidth(DataWidth)
    ) u_out_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .push     (in_flight_q),
        .push_data(bufDataOut),
        .pop      (fifo_pop),
        .head_data(fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .occupancy(fifo_occ)
    );

endmodule
